// File: rtl/cpu_ce_gen.sv
// CPU clock-enable generator: native/alt/turbo rates with contention gating and a
// drain-gap-start sequence so that rate changes never produce a short or doubled CPU clock.
module cpu_ce_gen #(
   parameter int NATIVE_DIV = 16,
   parameter int ALT_DIV    = 27,
   parameter int TURBO_DIV  = 8,
   parameter int GAP_CYCLES = 48
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic [1:0] mode_req,
   input  logic       wait_req,
   input  logic       throttle_off,
   output logic       ce_p,
   output logic       ce_n,
   output logic       ce_bus_p,
   output logic       ce_bus_n,
   output logic [1:0] mode_act,
   output logic       switching
);

   typedef enum logic [1:0] {RUN, DRAIN, GAP, START} state_t;

   localparam logic [5:0] NATIVE_MAX  = 6'(NATIVE_DIV - 1);
   localparam logic [5:0] NATIVE_HALF = 6'(NATIVE_DIV / 2);
   localparam logic [5:0] ALT_MAX     = 6'(ALT_DIV - 1);
   localparam logic [5:0] ALT_HALF    = 6'(ALT_DIV / 2);
   localparam logic [5:0] TURBO_MAX   = 6'(TURBO_DIV - 1);
   localparam logic [5:0] TURBO_HALF  = 6'(TURBO_DIV / 2);
   localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

   state_t     state_q, state_d;
   logic [5:0] base_cnt_q, base_cnt_d;
   logic [5:0] div_cnt_q, div_cnt_d;
   logic [7:0] gap_cnt_q, gap_cnt_d;
   logic [1:0] mode_act_q, mode_act_d;
   logic       cpu_en_q, cpu_en_d;
   logic       half_hit_q, half_hit_d;
   logic       ce_p_q, ce_p_d;
   logic       ce_n_q, ce_n_d;
   logic       ce_bus_p_q, ce_bus_p_d;
   logic       ce_bus_n_q, ce_bus_n_d;

   logic [1:0] mode_req_eff;
   logic [5:0] div_max;
   logic [5:0] div_half;
   logic       run_phase;

   always_comb begin
      mode_req_eff = (mode_req == 2'd3) ? 2'd0 : mode_req;

      case (mode_act_q)
         2'd1:    begin div_max = ALT_MAX;    div_half = ALT_HALF;    end
         2'd2:    begin div_max = TURBO_MAX;  div_half = TURBO_HALF;  end
         default: begin div_max = NATIVE_MAX; div_half = NATIVE_HALF; end
      endcase

      base_cnt_d = (base_cnt_q >= NATIVE_MAX) ? 6'd0 : base_cnt_q + 6'd1;
      div_cnt_d  = (div_cnt_q >= div_max) ? 6'd0 : div_cnt_q + 6'd1;
      half_hit_d = (div_cnt_q == div_half);

      // Contention is decided once per native period, at its start, so a period is all-or-nothing.
      cpu_en_d = cpu_en_q;
      if (mode_act_q != 2'd0) begin
         cpu_en_d = 1'b1;
      end else if (base_cnt_q == 6'd0) begin
         cpu_en_d = ~wait_req | throttle_off;
      end

      state_d    = state_q;
      gap_cnt_d  = gap_cnt_q;
      mode_act_d = mode_act_q;
      case (state_q)
         RUN: begin
            if (mode_req_eff != mode_act_q) state_d = DRAIN;
         end
         // half_hit_q marks the cycle the (possibly suppressed) final ce_n is presented.
         DRAIN: begin
            if (half_hit_q) begin
               state_d   = GAP;
               gap_cnt_d = 8'd0;
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d    = START;
               mode_act_d = mode_req_eff;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         START: begin
            if ((mode_act_q != 2'd0) || (base_cnt_q == NATIVE_MAX)) begin
               state_d   = RUN;
               div_cnt_d = 6'd0;
            end
         end
         default: state_d = RUN;
      endcase

      run_phase  = (state_q == RUN) || (state_q == DRAIN);
      ce_p_d     = run_phase && (div_cnt_q == 6'd0) && cpu_en_d;
      ce_n_d     = run_phase && (div_cnt_q == div_half) && cpu_en_d;
      ce_bus_p_d = (base_cnt_q == 6'd0);
      ce_bus_n_d = (base_cnt_q == NATIVE_HALF);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= RUN;
         base_cnt_q <= 6'd0;
         div_cnt_q  <= 6'd0;
         gap_cnt_q  <= 8'd0;
         mode_act_q <= 2'd0;
         cpu_en_q   <= 1'b1;
         half_hit_q <= 1'b0;
         ce_p_q     <= 1'b0;
         ce_n_q     <= 1'b0;
         ce_bus_p_q <= 1'b0;
         ce_bus_n_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_cnt_q <= base_cnt_d;
         div_cnt_q  <= div_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         mode_act_q <= mode_act_d;
         cpu_en_q   <= cpu_en_d;
         half_hit_q <= half_hit_d;
         ce_p_q     <= ce_p_d;
         ce_n_q     <= ce_n_d;
         ce_bus_p_q <= ce_bus_p_d;
         ce_bus_n_q <= ce_bus_n_d;
      end
   end

   assign ce_p      = ce_p_q;
   assign ce_n      = ce_n_q;
   assign ce_bus_p  = ce_bus_p_q;
   assign ce_bus_n  = ce_bus_n_q;
   assign mode_act  = mode_act_q;
   assign switching = (state_q != RUN);

endmodule

// File: tb/tb_cpu_ce_gen.sv
// Randomised bench for cpu_ce_gen: a timeline model predicts every enable from absolute
// cycle numbers, the switch schedule and the sampled contention inputs.
module tb_cpu_ce_gen;

   localparam int NDIV = 16;
   localparam int ADIV = 27;
   localparam int TDIV = 8;
   localparam int GAP  = 48;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] mode_req = 2'd0;
   logic       wait_req = 1'b0;
   logic       throttle_off = 1'b0;
   logic       ce_p, ce_n, ce_bus_p, ce_bus_n, switching;
   logic [1:0] mode_act;

   int checks = 0;
   int passes = 0;

   // Model state: absolute cycle number since reset release, and the switch timeline.
   int k, m_md, o_cyc, s_last, start_cyc, run_cyc;
   bit in_sw, cur_run, en_per, p_pend;

   cpu_ce_gen #(.NATIVE_DIV(NDIV), .ALT_DIV(ADIV), .TURBO_DIV(TDIV), .GAP_CYCLES(GAP)) dut (
      .clk_sys(clk_sys), .reset(reset), .mode_req(mode_req), .wait_req(wait_req),
      .throttle_off(throttle_off), .ce_p(ce_p), .ce_n(ce_n), .ce_bus_p(ce_bus_p),
      .ce_bus_n(ce_bus_n), .mode_act(mode_act), .switching(switching)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      if (obs == exp) passes++;
      else $display("[TB] FAIL %s cycle=%0d got=%0d want=%0d", tag, k, obs, exp);
   endtask

   function automatic int div_of(input int md);
      case (md)
         1:       return ADIV;
         2:       return TDIV;
         default: return NDIV;
      endcase
   endfunction

   task automatic model_init();
      k = 0; m_md = 0; o_cyc = 0; s_last = 0; start_cyc = -1; run_cyc = -1;
      in_sw = 0; cur_run = 1; en_per = 1; p_pend = 0;
   endtask

   // Advance the model to cycle k using the inputs that were present before edge k.
   task automatic model_step(input logic [1:0] mq, input logic wq, input logic tq);
      int d, rel, mq_eff;
      bit prev_run, act, exp_p, exp_n;
      k++;
      prev_run = cur_run;
      mq_eff = (mq == 2'd3) ? 0 : int'(mq);
      if (in_sw && k == start_cyc) begin
         m_md = mq_eff;
         run_cyc = k + 1;
         if (m_md == 0) while (run_cyc % NDIV != 0) run_cyc++;
      end
      if (in_sw && k == run_cyc) begin
         in_sw = 0;
         o_cyc = k;
      end
      if (!in_sw && prev_run && mq_eff != m_md) begin
         d = div_of(m_md);
         rel = (k - 1 - o_cyc) % d;
         in_sw = 1;
         s_last = k + ((d / 2 - rel + d) % d);
         start_cyc = s_last + GAP + 1;
         run_cyc = -1;
      end
      cur_run = !in_sw;

      d = div_of(m_md);
      act = in_sw ? (k <= s_last) : (k >= o_cyc + 1);
      exp_p = 0;
      exp_n = 0;
      if (act) begin
         rel = (k - 1 - o_cyc) % d;
         if (rel == 0) en_per = (m_md != 0) || !wq || tq;
         exp_p = (rel == 0) && en_per;
         exp_n = (rel == d / 2) && en_per;
      end

      checkOutput("ce_p", int'(ce_p), int'(exp_p));
      checkOutput("ce_n", int'(ce_n), int'(exp_n));
      checkOutput("ce_bus_p", int'(ce_bus_p), int'((k - 1) % NDIV == 0));
      checkOutput("ce_bus_n", int'(ce_bus_n), int'((k - 1) % NDIV == NDIV / 2));
      checkOutput("mode_act", int'(mode_act), m_md);
      checkOutput("switching", int'(switching), int'(in_sw));
      checkOutput("p_and_n", int'(ce_p && ce_n), 0);
      checkOutput("double_p", int'(ce_p && p_pend), 0);
      if (ce_p) p_pend = 1;
      if (ce_n) p_pend = 0;
   endtask

   task automatic step_cycle();
      logic [1:0] mq;
      logic wq, tq;
      mq = mode_req; wq = wait_req; tq = throttle_off;
      @(posedge clk_sys);
      #1;
      model_step(mq, wq, tq);
   endtask

   // wait_pct: chance per cycle of contention; chg_pm: per-mille chance of a new mode request.
   task automatic applyStimulus(input int n, input int wait_pct, input int chg_pm, input int thr_pct);
      for (int i = 0; i < n; i++) begin
         wait_req = ($urandom_range(99) < wait_pct);
         if (thr_pct > 0) throttle_off = ($urandom_range(99) < thr_pct);
         if ($urandom_range(999) < chg_pm) mode_req = 2'($urandom_range(3));
         step_cycle();
      end
   endtask

   task automatic check_reset_values();
      checkOutput("rst_ce_p", int'(ce_p), 0);
      checkOutput("rst_ce_n", int'(ce_n), 0);
      checkOutput("rst_bus_p", int'(ce_bus_p), 0);
      checkOutput("rst_bus_n", int'(ce_bus_n), 0);
      checkOutput("rst_mode", int'(mode_act), 0);
      checkOutput("rst_switching", int'(switching), 0);
   endtask

   initial begin
      model_init();
      repeat (3) @(posedge clk_sys);
      #1;
      check_reset_values();
      reset = 1'b0;

      // native rate, no contention
      applyStimulus(64, 0, 0, 0);
      // one held contention period, then with throttle bypass
      applyStimulus(16, 100, 0, 0);
      applyStimulus(48, 0, 0, 0);
      throttle_off = 1'b1;
      applyStimulus(48, 100, 0, 0);
      throttle_off = 1'b0;
      // 0 -> 1 with wait ignored, then 1 -> 0
      mode_req = 2'd1;
      applyStimulus(250, 50, 0, 0);
      mode_req = 2'd0;
      applyStimulus(150, 0, 0, 0);
      // 0 -> 2 redirected to 1 mid-switch
      mode_req = 2'd2;
      applyStimulus(40, 0, 0, 0);
      mode_req = 2'd1;
      applyStimulus(150, 0, 0, 0);
      // random soak including mode 3 and throttle toggling
      applyStimulus(2000, 30, 6, 20);
      throttle_off = 1'b0;

      // reset while in GAP of a 1 -> 2 switch
      mode_req = 2'd1;
      applyStimulus(160, 0, 0, 0);
      mode_req = 2'd2;
      applyStimulus(40, 0, 0, 0);
      checkOutput("pre_reset_switching", int'(switching), 1);
      reset = 1'b1;
      #1;
      check_reset_values();
      @(posedge clk_sys);
      #1;
      mode_req = 2'd0;
      model_init();
      reset = 1'b0;
      applyStimulus(120, 20, 0, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/cpu_ce_gen.md
Name: cpu_ce_gen

Overview:
- Parametrised CPU clock-enable generator with contention gating and glitch-free switching between native, alternate (ZX-speed) and turbo CPU rates.
- Sits between clk_sys and the T80pa CEN_p/CEN_n inputs.
- Also emits fixed-phase bus enables for the ASIC/video side.
- Successor to the fixed two-mode enable logic: per-mode dividers are parameters, a third turbo mode is added, and the switch guard gap is parametrised.

Parameters:
- NATIVE_DIV, 16, clk_sys cycles per CPU clock in mode 0; even, 4..64
- ALT_DIV, 27, clk_sys cycles per CPU clock in mode 1; any value 4..64
- TURBO_DIV, 8, clk_sys cycles per CPU clock in mode 2; even, 4..64
- GAP_CYCLES, 48, clk_sys cycles with no CPU enables during a mode switch; 1..255

Ports:
- clk_sys  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high
- mode_req  in  2  requested mode: 0 native, 1 alt, 2 turbo, 3 treated as 0
- wait_req  in  1  contention wait request; honoured in mode 0 only
- throttle_off  in  1  1 = ignore wait_req
- ce_p  out  1  CPU positive-phase enable, one clk_sys wide
- ce_n  out  1  CPU negative-phase enable, one clk_sys wide
- ce_bus_p  out  1  fixed native-rate positive-phase enable, never gated
- ce_bus_n  out  1  fixed native-rate negative-phase enable, never gated
- mode_act  out  2  mode currently driving ce_p/ce_n
- switching  out  1  high while a mode switch is in progress

Behaviour:
- Reset (async): all counters 0, state RUN, mode_act=0, cpu_en=1; ce_p, ce_n, ce_bus_p, ce_bus_n and switching all 0.
- base_cnt: free-runs 0..NATIVE_DIV-1 and wraps; ignores mode, wait and state.
  - ce_bus_p is high in the cycle after base_cnt==0.
  - ce_bus_n is high in the cycle after base_cnt==NATIVE_DIV/2.
- div_cnt: runs 0..D-1, where D is the divider of mode_act. In RUN:
  - ce_p is high in the cycle after div_cnt==0.
  - ce_n is high in the cycle after div_cnt==floor(D/2).
  - Outputs are registered: 1-cycle latency from the count match.
- cpu_en, mode 0:
  - Sampled when base_cnt==0: cpu_en <= ~wait_req | throttle_off.
  - cpu_en=0 suppresses ce_p and ce_n for that whole NATIVE_DIV period; div_cnt keeps counting.
  - wait_req changes mid-period take effect at the next base_cnt==0.
- cpu_en, modes 1 and 2: forced to 1.
- State RUN:
  - If mode_req (3 mapped to 0) != mode_act, go to DRAIN and assert switching.
- State DRAIN:
  - Continue normal enables until the cycle in which ce_n is emitted; next cycle go to GAP.
  - A suppressed ce_n (cpu_en=0) counts as emitted, so DRAIN never stalls longer than one CPU period.
- State GAP:
  - ce_p and ce_n held 0 for exactly GAP_CYCLES cycles, then go to START.
- State START:
  - Latch mode_act <= current mode_req at entry.
  - Target 0: wait until base_cnt==NATIVE_DIV-1, then load div_cnt=0 and go to RUN. The first native ce_p coincides with ce_bus_p.
  - Targets 1 and 2: load div_cnt=0 and go to RUN next cycle.
  - switching drops on the cycle RUN is re-entered.
- mode_req changes during DRAIN/GAP:
  - No restart; the value at START wins.
  - If that value equals the old mode, the switch still completes (gap inserted, mode_act unchanged).
- Width: counters are 6 bits; the gap counter is 8 bits.
- Never emit ce_p and ce_n in the same cycle. Never emit two ce_p without an intervening ce_n, across switches included.
- Reset mid-switch returns immediately to the RUN/mode 0 reset values; the first ce_p is the cycle after the first post-reset base_cnt==0.

Test Plan:
- Mode 0, wait_req=0 after reset: ce_p every 16 cycles; ce_n exactly 8 cycles after each ce_p; ce_bus_p/ce_bus_n coincide with ce_p/ce_n.
- Mode 0, wait_req=1 held over one base_cnt==0 then released: exactly one ce_p/ce_n pair missing, ce_bus_* unaffected. Repeat with throttle_off=1: no pair missing.
- Switch 0->1: switching rises, one final ce_n, then ≥48 cycles with no ce_p/ce_n. Then ce_p every 27 cycles with ce_n 13 cycles after ce_p; mode_act=1; wait_req ignored.
- Switch 1->0: first native ce_p lands on the same cycle as a ce_bus_p; period 16 thereafter.
- mode_req 0->2, then 2->1 during GAP: mode_act ends at 1 with a period of 27; exactly one gap inserted.
- Assert reset during GAP: outputs 0 immediately, mode_act=0, switching=0; after release, native enables with period 16 and no double ce_p.
